// File: rtl/cpu_params_pkg.sv
// Shared CPU-wide definitions: CSR software operation encoding used by the
// decode stage and by every CSR storage element.
package cpu_params_pkg;

  // Software CSR access kind, matching the funct3[1:0] encoding of CSRRW/S/C.
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_WR   = 2'b01,
    CSR_OP_SET  = 2'b10,
    CSR_OP_CLR  = 2'b11
  } csr_op_t;

  localparam int CSR_SZ_DEFAULT = 32;

endpackage

// File: rtl/csr_nxt_val.sv
// Next-value logic for one CSR: software op, hardware capture, hardware
// set/clear masks and optional counter increment, in that precedence.
// Read-only and reserved bits always come out as their INIT value.
import cpu_params_pkg::*;

module csr_nxt_val #(
  parameter int            SZ          = CSR_SZ_DEFAULT,
  parameter logic [SZ-1:0] INIT        = '0,
  parameter logic [SZ-1:0] RO_BITS     = '0,
  parameter logic [SZ-1:0] WPRI_BITS   = '0,
  parameter bit            CNT_MODE    = 1'b0,
  parameter bit            HW_PRIORITY = 1'b1
) (
  input  logic [SZ-1:0] cur_i,
  input  logic [1:0]    sw_op_i,
  input  logic [SZ-1:0] sw_wdata_i,
  input  logic          hw_wr_i,
  input  logic [SZ-1:0] hw_wdata_i,
  input  logic [SZ-1:0] hw_set_i,
  input  logic [SZ-1:0] hw_clr_i,
  input  logic          cnt_inc_i,
  input  logic          cnt_inhibit_i,
  output logic [SZ-1:0] nxt_o,
  output logic          ovf_o
);

  localparam logic [SZ-1:0] ALL_RO = RO_BITS | WPRI_BITS;
  localparam logic [SZ-1:0] WR_MSK = ~ALL_RO;
  localparam logic [SZ-1:0] RO_VAL = INIT & ALL_RO;

  csr_op_t       op;
  logic          sw_act;
  logic          inc_act;
  logic [SZ-1:0] sw_val;
  logic [SZ-1:0] wr_val;
  logic [SZ-1:0] hw_val;
  logic [SZ-1:0] cnt_src;
  logic [SZ-1:0] cnt_sum;

  assign op     = csr_op_t'(sw_op_i);
  assign sw_act = (op != CSR_OP_NONE);

  // Software result as if the op were applied to the whole register.
  always_comb begin
    sw_val = cur_i;
    case (op)
      CSR_OP_WR:  sw_val = sw_wdata_i;
      CSR_OP_SET: sw_val = cur_i | sw_wdata_i;
      CSR_OP_CLR: sw_val = cur_i & ~sw_wdata_i;
      default:    sw_val = cur_i;
    endcase
  end

  // Arbitrate hardware capture against the software op; the loser is dropped.
  always_comb begin
    wr_val = cur_i;
    if (hw_wr_i && sw_act) begin
      wr_val = HW_PRIORITY ? hw_wdata_i : sw_val;
    end else if (hw_wr_i) begin
      wr_val = hw_wdata_i;
    end else if (sw_act) begin
      wr_val = sw_val;
    end
  end

  // Set mask first, clear mask last so clear wins on a shared bit.
  assign hw_val = (wr_val | hw_set_i) & ~hw_clr_i;

  // A write of either kind suppresses counting so the written value lands exactly.
  assign inc_act = CNT_MODE && cnt_inc_i && !cnt_inhibit_i && !(hw_wr_i || sw_act);

  // Forcing read-only bits to one lets the carry ripple straight across them,
  // so the writable bits behave as one contiguous counter.
  assign cnt_src = hw_val | ALL_RO;
  assign cnt_sum = cnt_src + SZ'(1);

  assign nxt_o = ((inc_act ? cnt_sum : hw_val) & WR_MSK) | RO_VAL;
  assign ovf_o = inc_act && (&cnt_src) && (|WR_MSK);

endmodule

// File: rtl/csr_rw_ff.sv
// Generic CSR storage element: holds the register value and the one-cycle
// acknowledge, change and overflow pulses. Next-value logic lives in csr_nxt_val.
import cpu_params_pkg::*;

module csr_rw_ff #(
  parameter int            SZ          = CSR_SZ_DEFAULT,
  parameter logic [SZ-1:0] INIT        = '0,
  parameter logic [SZ-1:0] RO_BITS     = '0,
  parameter logic [SZ-1:0] WPRI_BITS   = '0,
  parameter bit            CNT_MODE    = 1'b0,
  parameter bit            HW_PRIORITY = 1'b1
) (
  input  logic          clk_in,
  input  logic          reset_n_in,
  input  logic [1:0]    sw_op_in,
  input  logic [SZ-1:0] sw_wdata_in,
  input  logic          hw_wr_in,
  input  logic [SZ-1:0] hw_wdata_in,
  input  logic [SZ-1:0] hw_set_in,
  input  logic [SZ-1:0] hw_clr_in,
  input  logic          cnt_inc_in,
  input  logic          cnt_inhibit_in,
  output logic [SZ-1:0] csr_name_out,
  output logic          sw_ack_out,
  output logic          chg_out,
  output logic          ovf_out
);

  logic [SZ-1:0] val_q, val_d;
  logic          ack_q, ack_d;
  logic          chg_q, chg_d;
  logic          ovf_q, ovf_d;
  logic [SZ-1:0] nxt;
  logic          ovf_nxt;

  csr_nxt_val #(
    .SZ          (SZ),
    .INIT        (INIT),
    .RO_BITS     (RO_BITS),
    .WPRI_BITS   (WPRI_BITS),
    .CNT_MODE    (CNT_MODE),
    .HW_PRIORITY (HW_PRIORITY)
  ) u_nxt (
    .cur_i         (val_q),
    .sw_op_i       (sw_op_in),
    .sw_wdata_i    (sw_wdata_in),
    .hw_wr_i       (hw_wr_in),
    .hw_wdata_i    (hw_wdata_in),
    .hw_set_i      (hw_set_in),
    .hw_clr_i      (hw_clr_in),
    .cnt_inc_i     (cnt_inc_in),
    .cnt_inhibit_i (cnt_inhibit_in),
    .nxt_o         (nxt),
    .ovf_o         (ovf_nxt)
  );

  // Next state for the value and the three status pulses.
  always_comb begin
    val_d = nxt;
    ack_d = (csr_op_t'(sw_op_in) != CSR_OP_NONE);
    chg_d = (nxt != val_q);
    ovf_d = ovf_nxt;
  end

  // Register value and pulses; reset returns everything to INIT / idle at once.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      val_q <= INIT;
      ack_q <= 1'b0;
      chg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      val_q <= val_d;
      ack_q <= ack_d;
      chg_q <= chg_d;
      ovf_q <= ovf_d;
    end
  end

  assign csr_name_out = val_q;
  assign sw_ack_out   = ack_q;
  assign chg_out      = chg_q;
  assign ovf_out      = ovf_q;

endmodule

// File: tb/tb_csr_rw_ff.sv
// Directed bench for csr_rw_ff: several parameterisations share one set of
// stimulus wires; each vector names the instance whose outputs it checks.
module tb_csr_rw_ff;

  localparam int D_P = 0;  // plain, hardware priority
  localparam int D_S = 1;  // plain, software priority
  localparam int D_C = 2;  // counter
  localparam int D_W = 3;  // WPRI bit 11
  localparam int D_R = 4;  // INIT/RO 0x1800

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  sw_op;
  logic [31:0] sw_wdata;
  logic        hw_wr;
  logic [31:0] hw_wdata, hw_set, hw_clr;
  logic        cnt_inc, cnt_inh;

  logic [31:0] val_p, val_s, val_c, val_w, val_r;
  logic [4:0]  ack_o, chg_o, ovf_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_rw_ff #(.SZ(32), .HW_PRIORITY(1'b1)) u_p (
    .clk_in(clk), .reset_n_in(reset_n), .sw_op_in(sw_op), .sw_wdata_in(sw_wdata),
    .hw_wr_in(hw_wr), .hw_wdata_in(hw_wdata), .hw_set_in(hw_set), .hw_clr_in(hw_clr),
    .cnt_inc_in(cnt_inc), .cnt_inhibit_in(cnt_inh), .csr_name_out(val_p),
    .sw_ack_out(ack_o[D_P]), .chg_out(chg_o[D_P]), .ovf_out(ovf_o[D_P]));

  csr_rw_ff #(.SZ(32), .HW_PRIORITY(1'b0)) u_s (
    .clk_in(clk), .reset_n_in(reset_n), .sw_op_in(sw_op), .sw_wdata_in(sw_wdata),
    .hw_wr_in(hw_wr), .hw_wdata_in(hw_wdata), .hw_set_in(hw_set), .hw_clr_in(hw_clr),
    .cnt_inc_in(cnt_inc), .cnt_inhibit_in(cnt_inh), .csr_name_out(val_s),
    .sw_ack_out(ack_o[D_S]), .chg_out(chg_o[D_S]), .ovf_out(ovf_o[D_S]));

  csr_rw_ff #(.SZ(32), .CNT_MODE(1'b1)) u_c (
    .clk_in(clk), .reset_n_in(reset_n), .sw_op_in(sw_op), .sw_wdata_in(sw_wdata),
    .hw_wr_in(hw_wr), .hw_wdata_in(hw_wdata), .hw_set_in(hw_set), .hw_clr_in(hw_clr),
    .cnt_inc_in(cnt_inc), .cnt_inhibit_in(cnt_inh), .csr_name_out(val_c),
    .sw_ack_out(ack_o[D_C]), .chg_out(chg_o[D_C]), .ovf_out(ovf_o[D_C]));

  csr_rw_ff #(.SZ(32), .WPRI_BITS(32'h0000_0800)) u_w (
    .clk_in(clk), .reset_n_in(reset_n), .sw_op_in(sw_op), .sw_wdata_in(sw_wdata),
    .hw_wr_in(hw_wr), .hw_wdata_in(hw_wdata), .hw_set_in(hw_set), .hw_clr_in(hw_clr),
    .cnt_inc_in(cnt_inc), .cnt_inhibit_in(cnt_inh), .csr_name_out(val_w),
    .sw_ack_out(ack_o[D_W]), .chg_out(chg_o[D_W]), .ovf_out(ovf_o[D_W]));

  csr_rw_ff #(.SZ(32), .INIT(32'h0000_1800), .RO_BITS(32'h0000_1800)) u_r (
    .clk_in(clk), .reset_n_in(reset_n), .sw_op_in(sw_op), .sw_wdata_in(sw_wdata),
    .hw_wr_in(hw_wr), .hw_wdata_in(hw_wdata), .hw_set_in(hw_set), .hw_clr_in(hw_clr),
    .cnt_inc_in(cnt_inc), .cnt_inhibit_in(cnt_inh), .csr_name_out(val_r),
    .sw_ack_out(ack_o[D_R]), .chg_out(chg_o[D_R]), .ovf_out(ovf_o[D_R]));

  typedef struct {
    bit          rst;
    int          dut;
    logic [1:0]  op;
    logic [31:0] wd;
    logic        hw;
    logic [31:0] hwd;
    logic [31:0] hs;
    logic [31:0] hc;
    logic        inc;
    logic        inh;
    logic [31:0] ev;
    logic        ea;
    logic        ec;
    logic        eo;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rst, input int dut, input logic [1:0] op,
                              input logic [31:0] wd, input logic hw, input logic [31:0] hwd,
                              input logic [31:0] hs, input logic [31:0] hc,
                              input logic inc, input logic inh, input logic [31:0] ev,
                              input logic ea, input logic ec, input logic eo, input string nm);
    vec_t v;
    v.rst = rst; v.dut = dut; v.op = op; v.wd = wd; v.hw = hw; v.hwd = hwd;
    v.hs = hs; v.hc = hc; v.inc = inc; v.inh = inh; v.ev = ev;
    v.ea = ea; v.ec = ec; v.eo = eo; v.nm = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic sample(input int d, output logic [31:0] v);
    case (d)
      D_P:     v = val_p;
      D_S:     v = val_s;
      D_C:     v = val_c;
      D_W:     v = val_w;
      default: v = val_r;
    endcase
  endtask

  task automatic idle();
    sw_op = 2'b00; sw_wdata = '0; hw_wr = 1'b0; hw_wdata = '0;
    hw_set = '0; hw_clr = '0; cnt_inc = 1'b0; cnt_inh = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    idle();

    // Async reset assertion before any clock edge.
    #1 reset_n = 1'b0;
    #2;
    chk("rst_val_r", val_r, 32'h0000_1800);
    chk("rst_val_p", val_p, 32'h0);
    chk("rst_ack", {27'd0, ack_o}, 32'h0);
    chk("rst_chg", {27'd0, chg_o}, 32'h0);
    chk("rst_ovf", {27'd0, ovf_o}, 32'h0);

    // RO bits hold INIT whatever software writes.
    @(negedge clk); reset_n = 1'b1; sw_op = 2'b01; sw_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("r_wr_all_val", val_r, 32'hFFFF_FFFF);
    chk("r_wr_all_ack", {31'd0, ack_o[D_R]}, 32'd1);
    chk("r_wr_all_chg", {31'd0, chg_o[D_R]}, 32'd1);
    @(negedge clk); sw_op = 2'b11; sw_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("r_clr_all_val", val_r, 32'h0000_1800);
    @(negedge clk); sw_op = 2'b01; sw_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("r_wr_again_val", val_r, 32'hFFFF_FFFF);

    // Reset asserted mid-cycle with a write pending: immediate return to INIT.
    @(negedge clk); sw_op = 2'b01; sw_wdata = 32'hFFFF_FFFF;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_val_r", val_r, 32'h0000_1800);
    chk("midrst_ack_r", {31'd0, ack_o[D_R]}, 32'd0);
    chk("midrst_chg_r", {31'd0, chg_o[D_R]}, 32'd0);
    @(posedge clk); #1;
    chk("rst_held_val_r", val_r, 32'h0000_1800);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_wr_val", val_r, 32'hFFFF_FFFF);
    chk("post_rst_wr_ack", {31'd0, ack_o[D_R]}, 32'd1);

    //            rst  dut  op     wd             hw    hwd            hs             hc             inc   inh   ev             ack   chg   ovf
    vecs.push_back(mk(1, D_P, 2'b10, 32'h0000_00F0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_00F0, 1'b1, 1'b1, 1'b0, "set_f0"));
    vecs.push_back(mk(0, D_P, 2'b11, 32'h0000_0030, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_00C0, 1'b1, 1'b1, 1'b0, "clr_30"));
    vecs.push_back(mk(0, D_P, 2'b11, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_00C0, 1'b1, 1'b0, 1'b0, "clr_zero"));
    vecs.push_back(mk(0, D_P, 2'b00, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_00C0, 1'b0, 1'b0, 1'b0, "op_none"));
    vecs.push_back(mk(0, D_P, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_00C0, 1'b0, 1'b0, 1'b0, "plain_no_inc"));
    vecs.push_back(mk(1, D_P, 2'b01, 32'h1111_1111, 1'b1, 32'h2222_2222, 32'h0,         32'h0,         1'b0, 1'b0, 32'h2222_2222, 1'b1, 1'b1, 1'b0, "arb_hw_wins"));
    vecs.push_back(mk(1, D_S, 2'b01, 32'h1111_1111, 1'b1, 32'h2222_2222, 32'h0,         32'h0,         1'b0, 1'b0, 32'h1111_1111, 1'b1, 1'b1, 1'b0, "arb_sw_wins"));
    vecs.push_back(mk(0, D_S, 2'b00, 32'h0,         1'b1, 32'h3333_3333, 32'h0,         32'h0,         1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b1, 1'b0, "hw_wr_alone"));
    vecs.push_back(mk(1, D_P, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0000_0888, 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0808, 1'b0, 1'b1, 1'b0, "set_clr_conflict"));
    vecs.push_back(mk(1, D_W, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0000_0888, 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 1'b0, "wpri_set_clr"));
    vecs.push_back(mk(0, D_W, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'hFFFF_F7FF, 1'b1, 1'b1, 1'b0, "wpri_wr_ones"));
    vecs.push_back(mk(0, D_W, 2'b11, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, "wpri_clr_ones"));
    vecs.push_back(mk(1, D_P, 2'b10, 32'h0000_000F, 1'b1, 32'h0000_00F0, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_00E1, 1'b1, 1'b1, 1'b0, "cap_then_masks"));
    vecs.push_back(mk(1, D_C, 2'b01, 32'hFFFF_FFFE, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, "cnt_load"));
    vecs.push_back(mk(0, D_C, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, "cnt_inc1"));
    vecs.push_back(mk(0, D_C, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, "cnt_wrap"));
    vecs.push_back(mk(0, D_C, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b1, 1'b0, "cnt_after_wrap"));
    vecs.push_back(mk(0, D_C, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, "cnt_inhibit"));
    vecs.push_back(mk(0, D_C, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, "cnt_idle"));
    vecs.push_back(mk(1, D_C, 2'b01, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 1'b0, "wr_beats_inc"));
    vecs.push_back(mk(0, D_C, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b1, 1'b0, "inc_after_wr"));
    vecs.push_back(mk(0, D_C, 2'b00, 32'h0,         1'b1, 32'h0000_0005, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0005, 1'b0, 1'b1, 1'b0, "hwwr_beats_inc"));
    vecs.push_back(mk(0, D_C, 2'b00, 32'h0,         1'b0, 32'h0,         32'h0000_0002, 32'h0,         1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 1'b0, "set_then_inc"));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      sw_op = vecs[i].op; sw_wdata = vecs[i].wd; hw_wr = vecs[i].hw; hw_wdata = vecs[i].hwd;
      hw_set = vecs[i].hs; hw_clr = vecs[i].hc; cnt_inc = vecs[i].inc; cnt_inh = vecs[i].inh;
      @(posedge clk); #1;
      sample(vecs[i].dut, v);
      chk({vecs[i].nm, "_val"}, v, vecs[i].ev);
      chk({vecs[i].nm, "_ack"}, {31'd0, ack_o[vecs[i].dut]}, {31'd0, vecs[i].ea});
      chk({vecs[i].nm, "_chg"}, {31'd0, chg_o[vecs[i].dut]}, {31'd0, vecs[i].ec});
      chk({vecs[i].nm, "_ovf"}, {31'd0, ovf_o[vecs[i].dut]}, {31'd0, vecs[i].eo});
    end

    @(negedge clk);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
